// File: rtl/stream_sort_checker.sv
// stream_sort_checker
//   AXI-stream sink placed on the output of the stream sorter. Checks each packet
//   as it arrives: beats must be non-decreasing (unsigned), and the packet must
//   not exceed 2**ADDR_WIDTH beats. Reports per-packet status and running
//   saturating counters.
//
//   Build option: define STREAM_SORT_CHECK_THROTTLE_EN to drive src_tready from a
//   16-bit LFSR (about 75% duty) so the upstream sorter sees backpressure.
//   Without it, src_tready is 1 in every cycle after reset release.
//
// Ports
//   clk, rst_n              clock (posedge), asynchronous active-low reset
//   src_tvalid/tready/      input stream; a beat is taken when tvalid && tready
//   tdata/tlast
//   clear                   synchronous clear of pkt_cnt/err_cnt, wins over increment
//   pkt_done                one-cycle pulse the cycle after a packet closes
//   pkt_ok, pkt_len         status and beat count of the last closed packet
//   pkt_cnt, err_cnt        closed packets / failed packets, saturating
//
// state    | meaning
// ---------+----------------------------------------------------------
// SM_FIRST | waiting for the first beat of a packet
// SM_BODY  | inside a packet, comparing each beat with the previous one
module stream_sort_checker #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  src_tvalid,
   output logic                  src_tready,
   input  logic [DATA_WIDTH-1:0] src_tdata,
   input  logic                  src_tlast,
   input  logic                  clear,
   output logic                  pkt_done,
   output logic                  pkt_ok,
   output logic [ADDR_WIDTH:0]   pkt_len,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt
);

   localparam logic [0:0]           SM_FIRST = 1'b0;
   localparam logic [0:0]           SM_BODY  = 1'b1;
   localparam logic [ADDR_WIDTH:0]  LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]  LEN_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

   logic [0:0]            sm;
   logic [0:0]            sm_nxt;
   logic [DATA_WIDTH-1:0] prev;
   logic [ADDR_WIDTH:0]   len;
   logic [ADDR_WIDTH:0]   len_inc;
   logic                  ord_err;
   logic                  ord_hit;
   logic                  run_q;
   logic                  accept;
   logic                  close;
   logic                  close_ok;
   logic [ADDR_WIDTH:0]   close_len;
   logic                  len_err;

   assign accept  = src_tvalid & src_tready;
   assign len_inc = len + LEN_ONE;
   assign ord_hit = (sm == SM_BODY) && (src_tdata < prev);

   // run_q keeps tready low during reset and raises it on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

`ifdef STREAM_SORT_CHECK_THROTTLE_EN
   logic [15:0] lfsr;

   // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 16'hACE1;
      else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign src_tready = run_q & (lfsr[0] | lfsr[1]);
`else
   assign src_tready = run_q;
`endif

   always_comb begin
      sm_nxt    = sm;
      close     = 1'b0;
      close_ok  = 1'b1;
      close_len = len_inc;
      len_err   = 1'b0;
      if (accept) begin
         if (sm == SM_FIRST) begin
            close_len = LEN_ONE;
            if (src_tlast) close  = 1'b1;
            else           sm_nxt = SM_BODY;
         end else begin
            // A packet that reaches capacity without tlast is cut here; the next
            // beat starts a fresh packet.
            len_err  = !src_tlast && (len_inc == LEN_MAX);
            close    = src_tlast || len_err;
            close_ok = !(ord_err | ord_hit | len_err);
            if (close) sm_nxt = SM_FIRST;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sm      <= SM_FIRST;
         prev    <= '0;
         len     <= '0;
         ord_err <= 1'b0;
      end else begin
         sm <= sm_nxt;
         if (accept) begin
            prev <= src_tdata;
            if (sm == SM_FIRST) begin
               len     <= LEN_ONE;
               ord_err <= 1'b0;
            end else begin
               len     <= len_inc;
               ord_err <= ord_err | ord_hit;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_done <= 1'b0;
         pkt_ok   <= 1'b0;
         pkt_len  <= '0;
      end else begin
         pkt_done <= close;
         if (close) begin
            pkt_ok  <= close_ok;
            pkt_len <= close_len;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else if (clear) begin
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else if (close) begin
         if (pkt_cnt != CNT_MAX)              pkt_cnt <= pkt_cnt + CNT_ONE;
         if (!close_ok && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_stream_sort_checker.sv
// Directed bench for stream_sort_checker with ADDR_WIDTH=3 (max packet 8 beats)
// and CNT_WIDTH=4 (counters saturate at 15).
module tb_stream_sort_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       src_tvalid = 1'b0;
   logic       src_tready;
   logic [7:0] src_tdata = 8'h00;
   logic       src_tlast = 1'b0;
   logic       clear = 1'b0;
   logic       pkt_done;
   logic       pkt_ok;
   logic [3:0] pkt_len;
   logic [3:0] pkt_cnt;
   logic [3:0] err_cnt;

   int tests_run = 0;
   int failures  = 0;

   stream_sort_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .CNT_WIDTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .src_tvalid (src_tvalid),
      .src_tready (src_tready),
      .src_tdata  (src_tdata),
      .src_tlast  (src_tlast),
      .clear      (clear),
      .pkt_done   (pkt_done),
      .pkt_ok     (pkt_ok),
      .pkt_len    (pkt_len),
      .pkt_cnt    (pkt_cnt),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one beat and returns #1 after the edge on which it was taken.
   // tvalid stays high so a following send() is back-to-back.
   task automatic send(input logic [7:0] d, input logic l);
      logic ok;
      int   n;
      src_tvalid = 1'b1;
      src_tdata  = d;
      src_tlast  = l;
      n = 0;
      do begin
         ok = src_tready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 64);
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      src_tvalid = 1'b0;
      src_tlast  = 1'b0;
      src_tdata  = 8'h00;
      @(posedge clk);
      #1;
   endtask

   task automatic check_close(input string tag, input logic ok, input logic [3:0] len,
                              input logic [3:0] cnt, input logic [3:0] err);
      check({tag, "_done"}, pkt_done, 1'b1);
      check({tag, "_ok"},   pkt_ok,   ok);
      check({tag, "_len"},  pkt_len,  len);
      check({tag, "_cnt"},  pkt_cnt,  cnt);
      check({tag, "_err"},  err_cnt,  err);
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] m);
      return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
   endfunction

   initial begin
      logic [15:0] m;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_tready", src_tready, 1'b0);
      check("rst_done",   pkt_done,   1'b0);
      check("rst_ok",     pkt_ok,     1'b0);
      check("rst_len",    pkt_len,    4'd0);
      check("rst_cnt",    pkt_cnt,    4'd0);
      check("rst_err",    err_cnt,    4'd0);

      // ready pattern after release
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m = 16'hACE1;
      for (int i = 0; i < 20; i++) begin
`ifdef STREAM_SORT_CHECK_THROTTLE_EN
         m = lfsr_step(m);
         check("tready_lfsr", src_tready, m[0] | m[1]);
`else
         check("tready_on", src_tready, 1'b1);
`endif
         @(posedge clk);
         #1;
      end

      // sorted 4-beat packet with a repeated value
      send(8'h03, 1'b0);
      send(8'h05, 1'b0);
      send(8'h05, 1'b0);
      send(8'h09, 1'b1);
      check_close("sorted4", 1'b1, 4'd4, 4'd1, 4'd0);
      idle();
      check("done_pulse_1cyc", pkt_done, 1'b0);
      check("ok_hold", pkt_ok, 1'b1);

      // unsorted packet then a single-beat packet
      send(8'h07, 1'b0);
      send(8'h02, 1'b0);
      send(8'h08, 1'b1);
      check_close("unsorted3", 1'b0, 4'd3, 4'd2, 4'd1);
      idle();
      send(8'h00, 1'b1);
      check_close("single", 1'b1, 4'd1, 4'd3, 4'd1);
      idle();

      // over-length: 8 beats without tlast closes with len_err
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
      check_close("overlen", 1'b0, 4'd8, 4'd4, 4'd2);
      // beat 9 is a first beat: 0 < 8 would be an order error otherwise
      send(8'h00, 1'b1);
      check_close("after_overlen", 1'b1, 4'd1, 4'd5, 4'd2);

      // back-to-back, tvalid held high throughout
      send(8'h04, 1'b0);
      send(8'h06, 1'b1);
      check_close("b2b_a", 1'b1, 4'd2, 4'd6, 4'd2);
      send(8'h01, 1'b0);
      check("b2b_gap_done", pkt_done, 1'b0);
      send(8'h02, 1'b1);
      check_close("b2b_b", 1'b1, 4'd2, 4'd7, 4'd2);
      idle();

      // reset mid-packet
      send(8'h05, 1'b0);
      send(8'h06, 1'b0);
      src_tvalid = 1'b0;
      src_tlast  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_tready", src_tready, 1'b0);
      check("arst_ok",     pkt_ok,     1'b0);
      check("arst_len",    pkt_len,    4'd0);
      check("arst_cnt",    pkt_cnt,    4'd0);
      check("arst_err",    err_cnt,    4'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(8'h01, 1'b0);
      send(8'h02, 1'b1);
      check_close("post_rst", 1'b1, 4'd2, 4'd1, 4'd0);
      idle();

      // clear together with a close
      send(8'h03, 1'b0);
      clear = 1'b1;
      send(8'h04, 1'b1);
      clear = 1'b0;
      check_close("clear_close", 1'b1, 4'd2, 4'd0, 4'd0);
      idle();

      // clear alone leaves packet status untouched
      send(8'h09, 1'b0);
      send(8'h01, 1'b1);
      check_close("pre_clear", 1'b0, 4'd2, 4'd1, 4'd1);
      src_tvalid = 1'b0;
      src_tlast  = 1'b0;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("clear_cnt",  pkt_cnt, 4'd0);
      check("clear_err",  err_cnt, 4'd0);
      check("clear_ok",   pkt_ok,  1'b0);
      check("clear_len",  pkt_len, 4'd2);

      // saturation: 17 failing packets with 4-bit counters
      for (int i = 0; i < 17; i++) begin
         send(8'h02, 1'b0);
         send(8'h01, 1'b1);
      end
      check_close("saturate", 1'b0, 4'd2, 4'd15, 4'd15);
      idle();

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
